// File: rtl/rf_wb_if.sv
// Bundle of all writeback-arbiter signals: ALU/LSU result handshakes, load-issue
// scoreboard port, hazard queries and the register-file write port.
interface rf_wb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Handshake rule for both alu_* and lsu_*: a transfer happens on the rising edge
  // where valid && ready are both 1. ready depends only on internal state, never on valid.
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [ADDR_WIDTH-1:0] chk_addr1;
  logic [ADDR_WIDTH-1:0] chk_addr2;
  logic                  chk_busy1;
  logic                  chk_busy2;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, chk_addr1, chk_addr2,
    output alu_ready, lsu_ready, chk_busy1, chk_busy2,
    output rf_wen, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, chk_addr1, chk_addr2,
    input  alu_ready, lsu_ready, chk_busy1, chk_busy2,
    input  rf_wen, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Register-file write master: merges ALU results with buffered LSU load returns
// and tracks per-register busy bits for outstanding loads.
module rf_writeback_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic     clk,
  input logic     rst,
  rf_wb_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] rd_mem_d   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  src_lsu_q, src_lsu_d;
  logic                  full, push, pop, take_alu;

  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    push     = bus.lsu_valid && !full;
    // A full FIFO always wins the port so loads cannot be starved by the ALU.
    pop      = full || (!bus.alu_valid && (count_q != '0));
    take_alu = bus.alu_valid && !full;

    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (push) begin
      rd_mem_d[tail_q]   = bus.lsu_rd;
      data_mem_d[tail_q] = bus.lsu_data;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    src_lsu_d = pop;
    if (pop) begin
      wen_d   = (rd_mem_q[head_q] != '0);
      waddr_d = rd_mem_q[head_q];
      wdata_d = data_mem_q[head_q];
    end else if (take_alu) begin
      wen_d   = (bus.alu_rd != '0);
      waddr_d = bus.alu_rd;
      wdata_d = bus.alu_data;
    end

    // Clear on the load's retiring edge, then set so a same-edge re-issue wins.
    busy_d = busy_q;
    if (wen_q && src_lsu_q) busy_d[waddr_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      src_lsu_q <= 1'b0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      src_lsu_q  <= src_lsu_d;
    end
  end

  assign bus.alu_ready  = !full;
  assign bus.lsu_ready  = !full;
  assign bus.chk_busy1  = busy_q[bus.chk_addr1];
  assign bus.chk_busy2  = busy_q[bus.chk_addr2];
  assign bus.rf_wen     = wen_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_rf_writeback_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  rf_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus ();

  rf_writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [(1<<AW)-1:0] m_busy = '0;
  logic               m_wen = 1'b0;
  logic [AW-1:0]      m_waddr = '0;
  logic [DW-1:0]      m_wdata = '0;
  logic               m_src = 1'b0;
  logic [AW+DW-1:0]   m_e;
  logic               m_full, m_push, m_ret;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_src = 1'b0;
    end else begin
      m_full = (exp_q.size() == D);
      m_push = bus.lsu_valid && !m_full;
      m_ret  = m_wen && m_src;
      if (m_ret) m_busy[m_waddr] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      if (m_full || (!bus.alu_valid && exp_q.size() > 0)) begin
        m_e     = exp_q.pop_front();
        m_waddr = m_e[AW+DW-1:DW];
        m_wdata = m_e[DW-1:0];
        m_wen   = (m_waddr != 0);
        m_src   = 1'b1;
      end else if (bus.alu_valid) begin
        m_waddr = bus.alu_rd;
        m_wdata = bus.alu_data;
        m_wen   = (bus.alu_rd != 0);
        m_src   = 1'b0;
      end else begin
        m_wen = 1'b0;
        m_src = 1'b0;
      end
      if (m_push) exp_q.push_back({bus.lsu_rd, bus.lsu_data});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      check("rf_wen", 64'(bus.rf_wen), 64'(m_wen));
      if (m_wen || !rst) begin
        check("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
        check("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
      end
      check("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
      check("alu_ready", 64'(bus.alu_ready), 64'(exp_q.size() < D));
      check("lsu_ready", 64'(bus.lsu_ready), 64'(exp_q.size() < D));
      check("chk_busy1", 64'(bus.chk_busy1), 64'((bus.chk_addr1 != 0) && m_busy[bus.chk_addr1]));
      check("chk_busy2", 64'(bus.chk_busy2), 64'((bus.chk_addr2 != 0) && m_busy[bus.chk_addr2]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic drive_iss(input logic v, input logic [AW-1:0] rd);
    bus.iss_valid = v; bus.iss_rd = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_alu(1'b1, 5'd3, 32'h11);
    drive_lsu(1'b0, '0, '0);
    drive_iss(1'b0, '0);
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;
    #2 rst = 1'b0;

    // reset holds outputs even with an ALU result offered
    repeat (3) tick();
    check("lit_reset_wen", 64'(bus.rf_wen), 64'(0));
    check("lit_reset_cnt", 64'(bus.fifo_count), 64'(0));
    rst = 1'b1;
    tick();
    check("lit_alu_wen", 64'(bus.rf_wen), 64'(1));
    check("lit_alu_waddr", 64'(bus.rf_waddr), 64'(3));
    check("lit_alu_wdata", 64'(bus.rf_wdata), 64'(32'h11));
    drive_alu(1'b0, '0, '0);

    // load flow
    drive_iss(1'b1, 5'd5);
    bus.chk_addr1 = 5'd5;
    #1 check("lit_busy_no_bypass", 64'(bus.chk_busy1), 64'(0));
    tick();
    drive_iss(1'b0, '0);
    check("lit_busy5_set", 64'(bus.chk_busy1), 64'(1));
    drive_lsu(1'b1, 5'd5, 32'hABCD);
    tick();
    drive_lsu(1'b0, '0, '0);
    check("lit_load_cnt1", 64'(bus.fifo_count), 64'(1));
    check("lit_load_wen0", 64'(bus.rf_wen), 64'(0));
    tick();
    check("lit_load_wen", 64'(bus.rf_wen), 64'(1));
    check("lit_load_waddr", 64'(bus.rf_waddr), 64'(5));
    check("lit_load_wdata", 64'(bus.rf_wdata), 64'(32'hABCD));
    check("lit_busy5_still", 64'(bus.chk_busy1), 64'(1));
    tick();
    check("lit_busy5_clr", 64'(bus.chk_busy1), 64'(0));

    // ALU contention and full back-pressure
    drive_alu(1'b1, 5'd1, 32'h100);
    drive_lsu(1'b1, 5'd7, 32'h77);
    tick();
    check("lit_cont_waddr1", 64'(bus.rf_waddr), 64'(1));
    check("lit_cont_cnt1", 64'(bus.fifo_count), 64'(1));
    drive_alu(1'b1, 5'd2, 32'h200);
    drive_lsu(1'b1, 5'd8, 32'h88);
    tick();
    check("lit_cont_waddr2", 64'(bus.rf_waddr), 64'(2));
    check("lit_cont_cnt2", 64'(bus.fifo_count), 64'(2));
    check("lit_full_alu_rdy", 64'(bus.alu_ready), 64'(0));
    check("lit_full_lsu_rdy", 64'(bus.lsu_ready), 64'(0));
    drive_alu(1'b1, 5'd3, 32'h300);
    drive_lsu(1'b1, 5'd10, 32'hAA);
    tick();
    check("lit_cont_waddr7", 64'(bus.rf_waddr), 64'(7));
    check("lit_cont_wdata77", 64'(bus.rf_wdata), 64'(32'h77));
    check("lit_no_third", 64'(bus.fifo_count), 64'(1));
    drive_lsu(1'b0, '0, '0);
    tick();
    check("lit_cont_waddr3", 64'(bus.rf_waddr), 64'(3));
    drive_alu(1'b0, '0, '0);
    tick();
    check("lit_cont_waddr8", 64'(bus.rf_waddr), 64'(8));
    check("lit_cont_wdata88", 64'(bus.rf_wdata), 64'(32'h88));
    check("lit_cont_empty", 64'(bus.fifo_count), 64'(0));

    // x0 handling
    drive_alu(1'b1, 5'd0, 32'h5);
    #1 check("lit_x0_alu_rdy", 64'(bus.alu_ready), 64'(1));
    tick();
    check("lit_x0_alu_wen", 64'(bus.rf_wen), 64'(0));
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b1, 5'd0, 32'h55);
    tick();
    drive_lsu(1'b0, '0, '0);
    tick();
    check("lit_x0_lsu_wen", 64'(bus.rf_wen), 64'(0));
    check("lit_x0_lsu_pop", 64'(bus.fifo_count), 64'(0));
    drive_iss(1'b1, 5'd0);
    bus.chk_addr2 = 5'd0;
    tick();
    drive_iss(1'b0, '0);
    check("lit_x0_busy", 64'(bus.chk_busy2), 64'(0));

    // set/clear collision on rd 9
    bus.chk_addr1 = 5'd9;
    drive_iss(1'b1, 5'd9);
    tick();
    drive_iss(1'b0, '0);
    drive_lsu(1'b1, 5'd9, 32'h99);
    tick();
    drive_lsu(1'b0, '0, '0);
    tick();
    check("lit_coll_wen", 64'(bus.rf_wen), 64'(1));
    drive_iss(1'b1, 5'd9);
    tick();
    drive_iss(1'b0, '0);
    check("lit_coll_busy", 64'(bus.chk_busy1), 64'(1));
    tick();
    check("lit_coll_busy_hold", 64'(bus.chk_busy1), 64'(1));

    // mixed directed traffic, model-checked every cycle
    for (int i = 0; i < 16; i++) begin
      drive_alu((i % 3) != 0, AW'(i + 11), 32'h1000 + 32'(i));
      drive_lsu((i % 2) == 0, AW'(i + 4), 32'h2000 + 32'(i));
      drive_iss((i % 4) == 1, AW'(i + 4));
      bus.chk_addr1 = AW'(i + 4);
      bus.chk_addr2 = AW'(i + 3);
      tick();
    end
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    drive_iss(1'b0, '0);
    repeat (4) tick();

    // reset mid-operation discards buffered loads
    drive_alu(1'b1, 5'd12, 32'h12);
    drive_lsu(1'b1, 5'd13, 32'h13);
    repeat (2) tick();
    rst = 1'b0;
    #2;
    check("lit_midrst_cnt", 64'(bus.fifo_count), 64'(0));
    check("lit_midrst_wen", 64'(bus.rf_wen), 64'(0));
    tick();
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    rst = 1'b1;
    tick();
    check("lit_postrst_wen", 64'(bus.rf_wen), 64'(0));
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
